// File: rtl/matrix_scan_pkg.sv
// Shared constants, state encoding and helpers for the 5x7 LED matrix scan sequencer.
// No ports. Optional build macro SCAN_BLANK_EN is consumed by matrix_scan_ctrl.
package matrix_scan_pkg;

  localparam int unsigned NUM_COLS = 5;
  localparam int unsigned NUM_ROWS = 7;
  // Out-of-range select: the pixel mux returns 0 for it.
  localparam logic [5:0]  SEL_IDLE = 6'd63;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StLoad   = 3'd1;
  localparam state_t StSample = 3'd2;
  localparam state_t StShow   = 3'd3;
  localparam state_t StBlank  = 3'd4;

  // Linear pixel index into the 35:1 mux; at most 4*7+6 = 34, so 6 bits never overflow.
  function automatic logic [5:0] pixel_sel(input logic [2:0] col, input logic [2:0] row);
    return 6'(col) * 6'(NUM_ROWS) + 6'(row);
  endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Column dwell down-counter for the matrix scan sequencer.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset (count = 0)
//   load_i     reload with DWELL_CYCLES-1 (asserted on the edge that enters SHOW)
//   expired_o  high while the count sits at its terminal value 0
module scan_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned DWELL_W      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic expired_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = DWELL_W'(DWELL_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for a 5x7 LED matrix fed by a 35:1 pixel mux. For each column it reads
// the seven pixels one at a time through the mux, then lights that column for
// DWELL_CYCLES clocks. Single-frame or continuous refresh.
// Build option: define SCAN_BLANK_EN to insert a one-cycle dark BLANK state after each
// column; without it the display holds the previous column until the next one is lit.
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   start_i        pulse, starts a frame from IDLE (ignored while busy)
//   continuous_i   level, sampled at the end of column 4: 1 = wrap to column 0
//   mux_out_i      pixel bit returned by the mux
//   mux_sel_o      pixel select, col*7+row, 63 when not reading
//   col_n_o        column drive, one-hot active-low
//   row_o          row drive, active-high
//   busy_o         high whenever not IDLE
//   frame_done_o   one-cycle pulse when a frame completes
module matrix_scan_ctrl
  import matrix_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned DWELL_W      = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       continuous_i,
  input  logic       mux_out_i,
  output logic [5:0] mux_sel_o,
  output logic [4:0] col_n_o,
  output logic [6:0] row_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  state_t     state_q, state_d;
  logic [2:0] col_q, col_d;
  logic [2:0] row_idx_q, row_idx_d;
  logic [6:0] row_buf_q, row_buf_d;
  logic [5:0] mux_sel_q, mux_sel_d;
  logic [4:0] col_n_q, col_n_d;
  logic [6:0] row_q, row_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       dwell_load;
  logic       dwell_expired;
  logic       advance;

  scan_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .DWELL_W     (DWELL_W)
  ) u_dwell (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (dwell_load),
    .expired_o(dwell_expired)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_idx_d    = row_idx_q;
    row_buf_d    = row_buf_q;
    frame_done_d = 1'b0;
    dwell_load   = 1'b0;
    advance      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StLoad;
          col_d     = 3'd0;
          row_idx_d = 3'd0;
        end
      end
      StLoad: state_d = StSample;
      StSample: begin
        // mux_sel has been stable for a full cycle, so mux_out is the addressed pixel.
        row_buf_d[row_idx_q] = mux_out_i;
        if (row_idx_q == 3'(NUM_ROWS - 1)) begin
          row_idx_d  = 3'd0;
          state_d    = StShow;
          dwell_load = 1'b1;
        end else begin
          row_idx_d = row_idx_q + 3'd1;
          state_d   = StLoad;
        end
      end
      StShow: begin
        if (dwell_expired) begin
`ifdef SCAN_BLANK_EN
          state_d = StBlank;
`else
          advance = 1'b1;
`endif
        end
      end
      StBlank: advance = 1'b1;
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (col_q != 3'(NUM_COLS - 1)) begin
        col_d   = col_q + 3'd1;
        state_d = StLoad;
      end else begin
        frame_done_d = 1'b1;
        if (continuous_i) begin
          col_d   = 3'd0;
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d    = (state_d != StIdle);
    mux_sel_d = SEL_IDLE;
    col_n_d   = col_n_q;
    row_d     = row_q;

    if (state_d == StLoad) begin
      mux_sel_d = pixel_sel(col_d, row_idx_d);
    end else if (state_d == StSample) begin
      mux_sel_d = mux_sel_q;
    end

    if (state_d == StShow && state_q != StShow) begin
      col_n_d = ~(5'd1 << col_q);
      row_d   = row_buf_d;
    end else if (state_d == StIdle || state_d == StBlank) begin
      col_n_d = 5'h1F;
      row_d   = 7'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      col_q        <= 3'd0;
      row_idx_q    <= 3'd0;
      row_buf_q    <= 7'd0;
      mux_sel_q    <= SEL_IDLE;
      col_n_q      <= 5'h1F;
      row_q        <= 7'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_idx_q    <= row_idx_d;
      row_buf_q    <= row_buf_d;
      mux_sel_q    <= mux_sel_d;
      col_n_q      <= col_n_d;
      row_q        <= row_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mux_sel_o    = mux_sel_q;
  assign col_n_o      = col_n_q;
  assign row_o        = row_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl with DWELL_CYCLES=4 and a behavioural 35:1 mux.
module tb_matrix_scan_ctrl;

  localparam int unsigned D = 4;
`ifdef SCAN_BLANK_EN
  localparam int unsigned B = 1;
`else
  localparam int unsigned B = 0;
`endif
  localparam int unsigned P     = 14 + D + B;   // cycles per column
  localparam int unsigned FRAME = 5 * P;
  localparam int unsigned LIT   = D + 14 * (1 - B);  // cycles a column stays on the display
  localparam int unsigned DARK  = (B == 1) ? (FRAME - 5 * D) : 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       mux_out;
  logic [5:0] mux_sel;
  logic [4:0] col_n;
  logic [6:0] row;
  logic       busy;
  logic       frame_done;
  logic [34:0] pix = '0;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_out = (mux_sel < 6'd35) ? pix[mux_sel] : 1'b0;

  matrix_scan_ctrl #(
    .DWELL_CYCLES(D),
    .DWELL_W     (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .continuous_i(continuous),
    .mux_out_i   (mux_out),
    .mux_sel_o   (mux_sel),
    .col_n_o     (col_n),
    .row_o       (row),
    .busy_o      (busy),
    .frame_done_o(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just a cycle index m_t within 0..FRAME-1 counted from the first LOAD.
  logic m_on = 1'b0;
  logic m_first = 1'b0;
  logic m_fd = 1'b0;
  int   m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on <= 1'b0; m_first <= 1'b0; m_fd <= 1'b0; m_t <= 0;
    end else begin
      m_fd <= 1'b0;
      if (!m_on) begin
        if (start) begin m_on <= 1'b1; m_t <= 0; m_first <= 1'b1; end
      end else if (m_t == FRAME - 1) begin
        m_fd <= 1'b1;
        if (continuous) begin m_t <= 0; m_first <= 1'b0; end
        else m_on <= 1'b0;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  function automatic logic [6:0] pattern(input int c);
    logic [6:0] p;
    for (int r = 0; r < 7; r++) p[r] = pix[c * 7 + r];
    return p;
  endfunction

  always @(negedge clk) begin : cmp
    logic [5:0] e_sel;
    logic [4:0] e_coln;
    logic [6:0] e_row;
    int c, off, shown;
    e_sel = 6'd63; e_coln = 5'h1F; e_row = 7'd0; shown = -1;
    if (m_on) begin
      c   = m_t / P;
      off = m_t % P;
      if (off < 14) e_sel = 6'(c * 7 + off / 2);
      if (off >= 14 && off < 14 + D) shown = c;
      else if (B == 0 && off < 14) begin
        if (c > 0) shown = c - 1;
        else if (!m_first) shown = 4;
      end
      if (shown >= 0) begin
        e_coln = ~(5'd1 << shown);
        e_row  = pattern(shown);
      end
    end
    check("mux_sel", mux_sel, e_sel);
    check("col_n", col_n, e_coln);
    check("row", row, e_row);
    check("busy", busy, m_on);
    check("frame_done", frame_done, m_fd);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Call on a frame's first cycle; returns on the cycle frame_done is seen.
  task automatic run_frame(input logic [4:0] lc, input logic [6:0] lr, output int len,
                           output int lit, output int dark, output int stray);
    len = 0; lit = 0; dark = 0; stray = 0;
    do begin
      if (busy && col_n == 5'h1F) dark++;
      if (col_n == lc && row == lr) lit++;
      if (row != 7'd0 && col_n != lc) stray++;
      tick();
      len++;
    end while (!frame_done && len < 3 * FRAME);
  endtask

  initial begin
    int len, lit, dark, stray, fs, n, fds;
    logic [63:0] rnd;

    // 1. reset
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mux_sel", mux_sel, 6'd63);
    check("rst_col_n", col_n, 5'h1F);
    check("rst_row", row, 7'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2. pixel 0 only, single frame
    pix = 35'd1;
    pulse_start();
    check("t2_first_sel", mux_sel, 6'd0);
    run_frame(5'b11110, 7'b0000001, len, lit, dark, stray);
    check("t2_frame_len", len, FRAME);
    check("t2_lit_cycles", lit, LIT);
    check("t2_dark_cycles", dark, DARK);
    check("t2_stray", stray, 0);
    check("t2_idle_busy", busy, 1'b0);
    tick();
    check("t2_fd_pulse", frame_done, 1'b0);

    // 3. pixel 34 only, continuous
    pix = 35'd1 << 34;
    continuous = 1'b1;
    pulse_start();
    run_frame(5'b01111, 7'b1000000, len, lit, dark, stray);
    check("t3_frame1_len", len, FRAME);
    check("t3_wrap_busy", busy, 1'b1);
    run_frame(5'b01111, 7'b1000000, len, lit, dark, stray);
    check("t3_frame2_len", len, FRAME);
    check("t3_lit_cycles", lit, LIT);
    check("t3_stray", stray, 0);

    // 4. start during col 2 SHOW ignored; drop continuous in col 3
    fs = cyc;
    repeat (2 * P + 15) tick();
    pulse_start();
    repeat (P) tick();
    continuous = 1'b0;
    n = 0;
    while (!frame_done && n < 2 * FRAME) begin tick(); n++; end
    check("t4_frame_len", cyc - fs, FRAME);
    check("t4_idle_busy", busy, 1'b0);

    // 5. reset during col 2 SHOW
    rnd = {$urandom, $urandom};
    pix = rnd[34:0];
    pulse_start();
    repeat (2 * P + 15) tick();
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_col_n", col_n, 5'h1F);
    check("t5_async_row", row, 7'd0);
    check("t5_async_busy", busy, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    fds = 0;
    repeat (2 * FRAME) begin tick(); if (frame_done) fds++; end
    check("t5_no_frame_done", fds, 0);
    pulse_start();
    check("t5_restart_sel", mux_sel, 6'd0);
    check("t5_restart_busy", busy, 1'b1);
    run_frame(5'b11111, 7'd0, len, lit, dark, stray);
    check("t5_frame_len", len, FRAME);
    tick();

    // randomized frames, start noise and continuous toggling
    for (int it = 0; it < 6; it++) begin
      rnd = {$urandom, $urandom};
      pix = rnd[34:0];
      continuous = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) tick();
      pulse_start();
      for (int k = 0; k < 3 * FRAME; k++) begin
        start = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 99) == 0) continuous = ~continuous;
        tick();
      end
      start = 1'b0;
      continuous = 1'b0;
      n = 0;
      while (busy && n < 2 * FRAME) begin tick(); n++; end
      check("rand_drain_busy", busy, 1'b0);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
